vga_scanout: RTL and testbench



---
 rtl/vga_scanout.sv | 181 ++++++++++++++++++
 tb/tb_vga_scanout.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// vga_scanout: raster timing generator, 16-entry palette lookup and registered RGB/sync/blank stage.
// Build macro SCANOUT_TEST_PATTERN_EN adds a test_mode input that swaps color_idx for DrawX[9:6] colour bars.
module vga_scanout #(
   parameter int CLK_DIV   = 2,
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       Clk,
   input  logic       Reset_n,
`ifdef SCANOUT_TEST_PATTERN_EN
   input  logic       test_mode,
`endif
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   input  logic [3:0] color_idx,
   output logic       pixel_ce,
   output logic       frame_start,
   output logic       hs,
   output logic       vs,
   output logic       blank_n,
   output logic [7:0] VGA_R,
   output logic [7:0] VGA_G,
   output logic [7:0] VGA_B
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
   localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   // Fixed 16-colour palette, RRGGBB.
   function automatic logic [23:0] palette_lookup(input logic [3:0] idx);
      logic [23:0] rgb;
      case (idx)
         4'd0:    rgb = 24'h000000;
         4'd1:    rgb = 24'h0000AA;
         4'd2:    rgb = 24'h00AA00;
         4'd3:    rgb = 24'h00AAAA;
         4'd4:    rgb = 24'hAA0000;
         4'd5:    rgb = 24'hAA00AA;
         4'd6:    rgb = 24'hAA5500;
         4'd7:    rgb = 24'hAAAAAA;
         4'd8:    rgb = 24'h555555;
         4'd9:    rgb = 24'hFFFFFF;
         4'd10:   rgb = 24'h5555FF;
         4'd11:   rgb = 24'h55FF55;
         4'd12:   rgb = 24'h55FFFF;
         4'd13:   rgb = 24'hFF5555;
         4'd14:   rgb = 24'hFFFF00;
         4'd15:   rgb = 24'hFF55FF;
         default: rgb = 24'h000000;
      endcase
      return rgb;
   endfunction

   function automatic logic in_window(input logic [9:0] v, input logic [9:0] lo, input logic [9:0] hi);
      return (v >= lo) && (v < hi);
   endfunction

   logic [DIV_W-1:0] div_q, div_d;
   logic             ce_q, ce_d;
   logic [9:0]       hc_q, hc_d;
   logic [9:0]       vc_q, vc_d;
   logic             fs_q, fs_d;
   logic             blank_q, blank_d;
   logic             hs_q, hs_d;
   logic             vs_q, vs_d;
   logic [23:0]      rgb_q, rgb_d;
   logic [3:0]       pix_idx_s;
   logic             vis_s;

   // Pixel divider and raster counters; ce is precomputed so it is a flop aligned with the divider.
   always_comb begin
      div_d = div_q;
      hc_d  = hc_q;
      vc_d  = vc_q;
      if (div_q == DIV_LAST) begin
         div_d = {DIV_W{1'b0}};
      end else begin
         div_d = div_q + DIV_W'(1);
      end
      ce_d = (div_d == DIV_LAST);
      if (ce_q) begin
         if (hc_q == H_LAST) begin
            hc_d = 10'd0;
            if (vc_q == V_LAST) begin
               vc_d = 10'd0;
            end else begin
               vc_d = vc_q + 10'd1;
            end
         end else begin
            hc_d = hc_q + 10'd1;
         end
      end else begin
         hc_d = hc_q;
      end
      // Flags the tick that will wrap the raster back to (0,0).
      fs_d = ce_d && (hc_d == H_LAST) && (vc_d == V_LAST);
   end

   // Output stage: colour, blank and syncs for the current coordinates, all captured on the same tick.
   always_comb begin
      pix_idx_s = color_idx;
`ifdef SCANOUT_TEST_PATTERN_EN
      if (test_mode) begin
         pix_idx_s = hc_q[9:6];
      end else begin
         pix_idx_s = color_idx;
      end
`endif
      vis_s   = (hc_q < H_VIS) && (vc_q < V_VIS);
      blank_d = blank_q;
      hs_d    = hs_q;
      vs_d    = vs_q;
      rgb_d   = rgb_q;
      if (ce_q) begin
         blank_d = vis_s;
         hs_d    = !in_window(hc_q, H_SYNC_BEG, H_SYNC_END);
         vs_d    = !in_window(vc_q, V_SYNC_BEG, V_SYNC_END);
         if (vis_s) begin
            rgb_d = palette_lookup(pix_idx_s);
         end else begin
            rgb_d = 24'h000000;
         end
      end else begin
         blank_d = blank_q;
      end
   end

   // All state; reset parks the raster at the top-left with syncs idle and colour black.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         div_q   <= {DIV_W{1'b0}};
         ce_q    <= 1'b0;
         hc_q    <= 10'd0;
         vc_q    <= 10'd0;
         fs_q    <= 1'b0;
         blank_q <= 1'b0;
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
         rgb_q   <= 24'h000000;
      end else begin
         div_q   <= div_d;
         ce_q    <= ce_d;
         hc_q    <= hc_d;
         vc_q    <= vc_d;
         fs_q    <= fs_d;
         blank_q <= blank_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         rgb_q   <= rgb_d;
      end
   end

   assign DrawX       = hc_q;
   assign DrawY       = vc_q;
   assign pixel_ce    = ce_q;
   assign frame_start = fs_q;
   assign hs          = hs_q;
   assign vs          = vs_q;
   assign blank_n     = blank_q;
   assign VGA_R       = rgb_q[23:16];
   assign VGA_G       = rgb_q[15:8];
   assign VGA_B       = rgb_q[7:0];

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a shrunken-geometry instance runs whole frames against a cycle-count model,
// a default-geometry instance checks the nominal line timing and the DrawX=100 renderer case.
`timescale 1ns/1ps
module tb_vga_scanout;

   localparam int HV = 128, HF = 4, HSY = 8, HB = 4;
   localparam int VV = 6,   VF = 2, VSY = 2, VB = 2;
   localparam int HT = HV + HF + HSY + HB;   // 144
   localparam int VT = VV + VF + VSY + VB;   // 12
   localparam int FR = HT * VT;              // 1728 pixels per small frame
   localparam int DHT = 800, DVT = 525;

   localparam logic [23:0] PAL [16] = '{24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
                                        24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
                                        24'h555555, 24'hFFFFFF, 24'h5555FF, 24'h55FF55,
                                        24'h55FFFF, 24'hFF5555, 24'hFFFF00, 24'hFF55FF};
   // hs(small), vs(small), frame_start(small), hs(default): period and asserted width in Clk cycles
   localparam int M_PER [4] = '{2 * HT, 2 * FR, 2 * FR, 1600};
   localparam int M_WID [4] = '{2 * HSY, 2 * VSY * HT, 1, 192};

   typedef struct {
      logic [3:0]  idx;
      logic [23:0] rgb;
   } pal_vec_t;

   typedef struct {
      bit ce; bit fs; bit hs; bit vs; bit bl;
      int x; int y;
      logic [23:0] rgb;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [9:0] d1_x, d1_y, d2_x, d2_y;
   logic [3:0] d1_idx, d2_idx;
   logic       d1_ce, d1_fs, d1_hs, d1_vs, d1_bl;
   logic       d2_ce, d2_fs, d2_hs, d2_vs, d2_bl;
   logic [7:0] d1_r, d1_g, d1_b, d2_r, d2_g, d2_b;
   logic       tm = 1'b0;

   logic       ren1_mode = 1'b1;
   logic [3:0] const_idx = 4'd0;
   logic [3:0] rnd_tab [FR];

   int  n_chk = 0, n_bad = 0;
   int  k_cnt = 0, cyc = 0;
   bit  mon1_en = 1'b0, mon2_en = 1'b1, meas_en = 1'b0;
   int  m_start [4];
   bit  m_have [4], m_prev [4];
   pal_vec_t pv [16];

   vga_scanout #(.CLK_DIV(2), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
                 .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB)) dut_small (
      .Clk(clk), .Reset_n(rst_n),
`ifdef SCANOUT_TEST_PATTERN_EN
      .test_mode(tm),
`endif
      .DrawX(d1_x), .DrawY(d1_y), .color_idx(d1_idx), .pixel_ce(d1_ce), .frame_start(d1_fs),
      .hs(d1_hs), .vs(d1_vs), .blank_n(d1_bl), .VGA_R(d1_r), .VGA_G(d1_g), .VGA_B(d1_b));

   vga_scanout dut_full (
      .Clk(clk), .Reset_n(rst_n),
`ifdef SCANOUT_TEST_PATTERN_EN
      .test_mode(tm),
`endif
      .DrawX(d2_x), .DrawY(d2_y), .color_idx(d2_idx), .pixel_ce(d2_ce), .frame_start(d2_fs),
      .hs(d2_hs), .vs(d2_vs), .blank_n(d2_bl), .VGA_R(d2_r), .VGA_G(d2_g), .VGA_B(d2_b));

   // Renderers: small instance reads a random per-pixel table or a constant; full instance lights DrawX=100.
   always_comb begin
      d1_idx = 4'd0;
      if (ren1_mode) d1_idx = const_idx;
      else if (int'(d1_y) < VT && int'(d1_x) < HT) d1_idx = rnd_tab[int'(d1_y) * HT + int'(d1_x)];
      else d1_idx = 4'd0;
   end
   assign d2_idx = (d2_x == 10'd100) ? 4'd9 : 4'd0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [48:0] pk(bit ce, bit fs, bit hs, bit vs, bit bl,
                                      logic [9:0] x, logic [9:0] y, logic [23:0] rgb);
      return {ce, fs, hs, vs, bl, x, y, rgb};
   endfunction

   // Expected state after k rising edges since reset release, derived from pixel counts alone.
   function automatic exp_t model(int k, bit full, logic [3:0] idx);
      exp_t e;
      int ht, vt, hv, hf, hsw, vv, vf, vsw, p, q, qx, qy;
      bit vis;
      ht = full ? DHT : HT; vt = full ? DVT : VT;
      hv = full ? 640 : HV; hf = full ? 16 : HF; hsw = full ? 96 : HSY;
      vv = full ? 480 : VV; vf = full ? 10 : VF; vsw = full ? 2 : VSY;
      p = k / 2;
      e.ce = (k % 2) == 1;
      e.x = p % ht;
      e.y = (p / ht) % vt;
      e.fs = e.ce && ((p % (ht * vt)) == ht * vt - 1);
      if (k < 2) begin
         e.hs = 1'b1; e.vs = 1'b1; e.bl = 1'b0; e.rgb = 24'h0;
      end else begin
         q = p - 1;
         qx = q % ht;
         qy = (q / ht) % vt;
         vis = (qx < hv) && (qy < vv);
         e.bl = vis;
         e.hs = !(qx >= hv + hf && qx < hv + hf + hsw);
         e.vs = !(qy >= vv + vf && qy < vv + vf + vsw);
         e.rgb = vis ? PAL[idx] : 24'h0;
      end
      return e;
   endfunction

   task automatic monitor_step();
      exp_t e;
      int q;
      logic [3:0] idx;
      if (!rst_n) begin
         k_cnt = 0;
         chk("reset_small", pk(d1_ce, d1_fs, d1_hs, d1_vs, d1_bl, d1_x, d1_y, {d1_r, d1_g, d1_b}),
             pk(0, 0, 1, 1, 0, 10'd0, 10'd0, 24'h0));
         chk("reset_full", pk(d2_ce, d2_fs, d2_hs, d2_vs, d2_bl, d2_x, d2_y, {d2_r, d2_g, d2_b}),
             pk(0, 0, 1, 1, 0, 10'd0, 10'd0, 24'h0));
      end else begin
         k_cnt++;
         q = (k_cnt / 2) - 1;
         if (q < 0) q = 0;
         if (mon1_en) begin
            idx = ren1_mode ? const_idx : rnd_tab[q % FR];
            e = model(k_cnt, 1'b0, idx);
            chk("model_small", pk(d1_ce, d1_fs, d1_hs, d1_vs, d1_bl, d1_x, d1_y, {d1_r, d1_g, d1_b}),
                pk(e.ce, e.fs, e.hs, e.vs, e.bl, 10'(e.x), 10'(e.y), e.rgb));
         end
         if (mon2_en) begin
            idx = ((q % DHT) == 100) ? 4'd9 : 4'd0;
            e = model(k_cnt, 1'b1, idx);
            chk("model_full", pk(d2_ce, d2_fs, d2_hs, d2_vs, d2_bl, d2_x, d2_y, {d2_r, d2_g, d2_b}),
                pk(e.ce, e.fs, e.hs, e.vs, e.bl, 10'(e.x), 10'(e.y), e.rgb));
         end
      end
   endtask

   task automatic measure_step();
      bit a [4];
      cyc++;
      a[0] = !d1_hs; a[1] = !d1_vs; a[2] = d1_fs; a[3] = !d2_hs;
      for (int i = 0; i < 4; i++) begin
         if (meas_en) begin
            if (a[i] && !m_prev[i]) begin
               if (m_have[i]) chk($sformatf("period_%0d", i), 64'(cyc - m_start[i]), 64'(M_PER[i]));
               m_start[i] = cyc;
               m_have[i] = 1'b1;
            end else if (!a[i] && m_prev[i] && m_have[i]) begin
               chk($sformatf("width_%0d", i), 64'(cyc - m_start[i]), 64'(M_WID[i]));
            end
         end else begin
            m_have[i] = 1'b0;
         end
         m_prev[i] = a[i];
      end
   endtask

   task automatic wait_to(input int t);
      int guard;
      guard = 0;
      while (k_cnt < t && guard < 20000) begin
         @(posedge clk); #2;
         guard++;
      end
      if (k_cnt < t) begin
         n_chk++; n_bad++;
         $display("FAIL wait_to: got k=%0d want %0d", k_cnt, t);
      end
   endtask

   initial begin
      int found, n14;
      pv[0]  = '{4'd0,  24'h000000}; pv[1]  = '{4'd1,  24'h0000AA};
      pv[2]  = '{4'd2,  24'h00AA00}; pv[3]  = '{4'd3,  24'h00AAAA};
      pv[4]  = '{4'd4,  24'hAA0000}; pv[5]  = '{4'd5,  24'hAA00AA};
      pv[6]  = '{4'd6,  24'hAA5500}; pv[7]  = '{4'd7,  24'hAAAAAA};
      pv[8]  = '{4'd8,  24'h555555}; pv[9]  = '{4'd9,  24'hFFFFFF};
      pv[10] = '{4'd10, 24'h5555FF}; pv[11] = '{4'd11, 24'h55FF55};
      pv[12] = '{4'd12, 24'h55FFFF}; pv[13] = '{4'd13, 24'hFF5555};
      pv[14] = '{4'd14, 24'hFFFF00}; pv[15] = '{4'd15, 24'hFF55FF};
      for (int i = 0; i < FR; i++) rnd_tab[i] = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin m_start[i] = 0; m_have[i] = 1'b0; m_prev[i] = 1'b0; end

      fork
         forever begin
            @(posedge clk); #1;
            monitor_step();
            measure_step();
         end
      join_none

      // Reset held, then released between edges.
      repeat (3) @(negedge clk);
      chk("rst_syncs", {d1_hs, d1_vs, d1_bl, d1_r, d1_g, d1_b}, {1'b1, 1'b1, 1'b0, 24'h0});
      rst_n = 1'b1;
      meas_en = 1'b1;
      #1;
      chk("ce_before_edge1", {d1_ce, d1_x}, {1'b0, 10'd0});
      wait_to(1); chk("ce_first",  {d1_ce, d1_x}, {1'b1, 10'd0});
      wait_to(2); chk("ce_gap",    {d1_ce, d1_x}, {1'b0, 10'd1});
      wait_to(3); chk("drawx_1",   {d1_ce, d1_x}, {1'b1, 10'd1});
      wait_to(5); chk("drawx_2",   {d1_ce, d1_x}, {1'b1, 10'd2});

      // Palette vectors on line 0 of the small instance (visible region).
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         const_idx = pv[i].idx;
         repeat (6) @(posedge clk);
         #2;
         chk($sformatf("palette_%0d", i), {d1_bl, d1_r, d1_g, d1_b}, {1'b1, pv[i].rgb});
      end

      // Full-size instance: only the pixel sampled at DrawX=100 is white.
      wait_to(201); chk("px99",  {d2_bl, d2_r, d2_g, d2_b}, {1'b1, 24'h000000});
      wait_to(202); chk("px100", {d2_bl, d2_r, d2_g, d2_b}, {1'b1, 24'hFFFFFF});
      wait_to(203); chk("px100b", {d2_bl, d2_r, d2_g, d2_b}, {1'b1, 24'hFFFFFF});
      wait_to(204); chk("px101", {d2_bl, d2_r, d2_g, d2_b}, {1'b1, 24'h000000});

      // Random renderer over two small frames.
      @(negedge clk);
      ren1_mode = 1'b0;
      repeat (4) @(posedge clk);
      mon1_en = 1'b1;
      repeat (4 * FR) @(posedge clk);

      // Constant index 14 for a whole frame: yellow only in the visible area.
      @(negedge clk);
      mon1_en = 1'b0;
      ren1_mode = 1'b1;
      const_idx = 4'd14;
      repeat (4) @(posedge clk);
      mon1_en = 1'b1;
      n14 = 0;
      for (int i = 0; i < 2 * FR; i++) begin
         @(posedge clk); #2;
         if ({d1_r, d1_g, d1_b} == 24'hFFFF00) n14++;
      end
      chk("yellow_cycles", 64'(n14), 64'(2 * HV * VV));

      // Asynchronous reset mid-line.
      meas_en = 1'b0;
      found = 0;
      for (int i = 0; i < 2 * FR + 10 && found == 0; i++) begin
         @(negedge clk);
         if (d1_x == 10'd30 && d1_y == 10'd4) found = 1;
      end
      chk("reach_30_4", 64'(found), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_small", {d1_x, d1_y, d1_hs, d1_vs, d1_bl, d1_r, d1_g, d1_b},
          {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 24'h0});
      chk("midrst_full", {d2_x, d2_y}, {10'd0, 10'd0});
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (300) @(posedge clk);

`ifdef SCANOUT_TEST_PATTERN_EN
      @(negedge clk);
      mon1_en = 1'b0;
      mon2_en = 1'b0;
      tm = 1'b1;
      found = 0;
      for (int i = 0; i < 4000 && found == 0; i++) begin
         @(negedge clk);
         if (d2_x == 10'd129 && d2_y < 10'd480) found = 1;
      end
      chk("bar_128", {d2_bl, d2_r, d2_g, d2_b}, {1'b1, 24'h00AA00});
      found = 0;
      for (int i = 0; i < 4000 && found == 0; i++) begin
         @(negedge clk);
         if (d2_x == 10'd577 && d2_y < 10'd480) found = 1;
      end
      chk("bar_576", {d2_bl, d2_r, d2_g, d2_b}, {1'b1, 24'hFFFFFF});
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
